// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux.
// Drives the registered select and grants, and registers accepted data with a valid flag.
module mux_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

   state_t          state, state_nxt, other_st;
   logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
   logic            last_b, last_b_nxt;
   logic            sel_nxt;
   logic            own_req, oth_req;
   logic            accept;

   assign gnt_a  = (state == GRANT_A);
   assign gnt_b  = (state == GRANT_B);
   assign accept = (gnt_a & req_a) | (gnt_b & req_b);

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      last_b_nxt   = last_b;
      sel_nxt      = sel;
      own_req      = (state == GRANT_B) ? req_b : req_a;
      oth_req      = (state == GRANT_B) ? req_a : req_b;
      other_st     = (state == GRANT_A) ? GRANT_B : GRANT_A;
      case (state)
         IDLE: begin
            if (req_a && req_b)  state_nxt = last_b ? GRANT_A : GRANT_B;
            else if (req_a)      state_nxt = GRANT_A;
            else if (req_b)      state_nxt = GRANT_B;
         end
         GRANT_A, GRANT_B: begin
            if (!own_req)
               state_nxt = oth_req ? other_st : IDLE;
            else if (oth_req && hold_cnt == HOLD_LAST)
               state_nxt = other_st;
            else
               // hold time is only bounded while the other side is waiting
               hold_cnt_nxt = oth_req ? hold_cnt + 1'b1 : '0;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         hold_cnt_nxt = '0;
         if (state != IDLE) last_b_nxt = (state == GRANT_B);
      end
      if (state_nxt == GRANT_A)      sel_nxt = 1'b0;
      else if (state_nxt == GRANT_B) sel_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         last_b    <= 1'b1;
         sel       <= 1'b0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         last_b    <= last_b_nxt;
         sel       <= sel_nxt;
         valid_out <= accept;
         if (accept) data_out <= sel ? data_b : data_a;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized scoreboard bench for mux_rr_arbiter against a per-cycle behavioural model.
module tb_mux_rr_arbiter;
   localparam int W  = 4;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         reset, req_a, req_b;
   logic [W-1:0] data_a, data_b;
   logic         gnt_a, gnt_b, sel, valid_out;
   logic [W-1:0] data_out;

   mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
      .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
      .sel(sel), .data_out(data_out), .valid_out(valid_out));

   always #5 clk = ~clk;

   typedef struct {
      logic         ga, gb, s, v;
      logic [W-1:0] d;
   } exp_t;
   exp_t q[$];

   int checks = 0, errors = 0;
   bit done = 0;

   // model: owner 0=none 1=A 2=B; last is the side most recently served
   int owner = 0, last = 2, cnt = 0;
   logic         m_sel = 0, m_v = 0;
   logic [W-1:0] m_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit ra, input bit rb,
                             input logic [W-1:0] da, input logic [W-1:0] db);
      int  nxt;
      bit  mine, other;
      exp_t e;
      if (rst) begin
         owner = 0; last = 2; cnt = 0; m_sel = 0; m_d = '0; m_v = 0;
      end else begin
         m_v = (owner == 1 && ra) || (owner == 2 && rb);
         if (m_v) m_d = m_sel ? db : da;
         mine  = (owner == 1) ? ra : rb;
         other = (owner == 1) ? rb : ra;
         if (owner == 0) begin
            if (ra && rb)  nxt = (last == 2) ? 1 : 2;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
            else           nxt = 0;
         end else if (!mine)
            nxt = other ? 3 - owner : 0;
         else if (other && cnt == MH - 1)
            nxt = 3 - owner;
         else
            nxt = owner;
         if (nxt != owner) begin
            if (owner != 0) last = owner;
            cnt = 0;
         end else if (owner != 0)
            cnt = other ? cnt + 1 : 0;
         owner = nxt;
         if (owner == 1) m_sel = 0;
         else if (owner == 2) m_sel = 1;
      end
      e.ga = (owner == 1); e.gb = (owner == 2); e.s = m_sel; e.v = m_v; e.d = m_d;
      q.push_back(e);
   endtask

   // modes: 0 random, 1 both, 2 A only, 3 B only, 4 none, 5 random+reset, 6 busy random
   int mode_tab[12] = '{1, 4, 2, 4, 2, 3, 3, 1, 0, 6, 5, 1};
   int len_tab[12]  = '{20, 2, 3, 2, 1, 2, 10, 12, 150, 150, 200, 10};

   initial begin
      reset = 1; req_a = 1; req_b = 1; data_a = '0; data_b = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         reset = 1; req_a = 1; req_b = 1;
         data_a = W'($urandom); data_b = W'($urandom);
         model_step(1, 1, 1, data_a, data_b);
      end
      for (int p = 0; p < 12; p++) begin
         for (int c = 0; c < len_tab[p]; c++) begin
            @(negedge clk);
            reset  = 0;
            data_a = W'($urandom);
            data_b = W'($urandom);
            case (mode_tab[p])
               1: begin req_a = 1; req_b = 1; end
               2: begin req_a = 1; req_b = 0; end
               3: begin req_a = 0; req_b = 1; end
               4: begin req_a = 0; req_b = 0; end
               6: begin req_a = ($urandom_range(9) < 8); req_b = ($urandom_range(9) < 8); end
               default: begin req_a = $urandom_range(1); req_b = $urandom_range(1); end
            endcase
            if (mode_tab[p] == 5 && $urandom_range(19) == 0) reset = 1;
            model_step(reset, req_a, req_b, data_a, data_b);
         end
      end
      @(negedge clk);
      reset = 0; req_a = 0; req_b = 0;
      @(negedge clk);
      done = 1;
   end

   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #1;
         check("gnt_overlap", {31'd0, gnt_a & gnt_b}, 32'd0);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("gnt_a", {31'd0, gnt_a}, {31'd0, e.ga});
            check("gnt_b", {31'd0, gnt_b}, {31'd0, e.gb});
            check("sel", {31'd0, sel}, {31'd0, e.s});
            check("valid_out", {31'd0, valid_out}, {31'd0, e.v});
            check("data_out", {{(32-W){1'b0}}, data_out}, {{(32-W){1'b0}}, e.d});
         end
      end
      check("queue_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
